// File: rtl/adrf_reg_sequencer_if.sv
// Word handshake between the ADRF register sequencer (master) and the SPI serializer (slave).
interface adrf_reg_sequencer_if;
  logic [23:0] WORD_DATA;
  logic        WORD_VALID;
  logic [3:0]  WORD_IDX;
  logic        WORD_READY;
  logic        WORD_DONE;

  modport master (
    output WORD_DATA, WORD_VALID, WORD_IDX,
    input  WORD_READY, WORD_DONE
  );

  modport slave (
    input  WORD_DATA, WORD_VALID, WORD_IDX,
    output WORD_READY, WORD_DONE
  );
endinterface

// File: rtl/adrf_reg_sequencer.sv
// Walks a table of 24-bit ADRF register words and hands them one at a time to the SPI
// serializer once the clock manager is locked, with inter-word gap and completion timeout.
module adrf_reg_sequencer #(
  parameter int unsigned NUM_WORDS = 8,
  parameter logic [24*NUM_WORDS-1:0] TABLE = {24'h000001, 24'h010000, 24'h020F00, 24'h030102,
                                              24'h041234, 24'h058000, 24'h0600FF, 24'h07A5A5},
  parameter int unsigned LOCK_CYCLES    = 1024,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                        GCLK,
  input  logic                        reset,
  input  logic                        CMT_LOCKED,
  input  logic                        SPI_EN,
  adrf_reg_sequencer_if.master        wif,
  output logic                        SEQ_BUSY,
  output logic                        SEQ_DONE,
  output logic                        SEQ_ERR
);

  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    IDX_LAST = 4'(NUM_WORDS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOCK_WAIT = 3'd1;
  localparam logic [2:0] S_LOAD      = 3'd2;
  localparam logic [2:0] S_HANDOFF   = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_GAP       = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;
  localparam logic [2:0] S_ERROR     = 3'd7;

  logic [23:0] table_w [16];

  for (genvar g = 0; g < 16; g++) begin : g_table
    if (g < NUM_WORDS) begin : g_used
      assign table_w[g] = TABLE[24*(NUM_WORDS-g)-1 -: 24];
    end else begin : g_unused
      assign table_w[g] = '0;
    end
  end

  logic          lock_meta_q, lock_s_q;
  logic          spi_en_q, spi_primed_q;
  logic [2:0]    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [23:0]   data_q, data_d;
  logic [3:0]    widx_q, widx_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          spi_rise;

  // An SPI_EN level already high when reset releases is not treated as a new request.
  assign spi_rise = SPI_EN & ~spi_en_q & spi_primed_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lock_cnt_d = lock_cnt_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    data_d     = data_q;
    widx_d     = widx_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (spi_rise) begin
          state_d    = S_LOCK_WAIT;
          lock_cnt_d = '0;
          idx_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      S_LOCK_WAIT: begin
        if (!lock_s_q) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_MAX) begin
          state_d    = S_LOAD;
          idx_d      = '0;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        data_d  = table_w[idx_q];
        widx_d  = idx_q;
        valid_d = 1'b1;
        state_d = S_HANDOFF;
      end
      S_HANDOFF: begin
        if (valid_q && wif.WORD_READY) begin
          valid_d = 1'b0;
          tmo_d   = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // Error flags are raised on the transition so SEQ_ERR lands exactly TIMEOUT_CYCLES after accept.
        if (wif.WORD_DONE) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_LOAD;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!lock_s_q && (state_q inside {S_LOAD, S_HANDOFF, S_WAIT_DONE, S_GAP})) begin
      valid_d    = 1'b0;
      idx_d      = '0;
      lock_cnt_d = '0;
      state_d    = S_LOCK_WAIT;
    end
  end

  always_ff @(posedge GCLK) begin
    if (reset) begin
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      spi_en_q     <= 1'b0;
      spi_primed_q <= 1'b0;
      state_q      <= S_IDLE;
      idx_q        <= '0;
      lock_cnt_q   <= '0;
      tmo_q        <= '0;
      gap_q        <= '0;
      data_q       <= '0;
      widx_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      lock_meta_q  <= CMT_LOCKED;
      lock_s_q     <= lock_meta_q;
      spi_en_q     <= SPI_EN;
      spi_primed_q <= 1'b1;
      state_q      <= state_d;
      idx_q        <= idx_d;
      lock_cnt_q   <= lock_cnt_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      data_q       <= data_d;
      widx_q       <= widx_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign wif.WORD_DATA  = data_q;
  assign wif.WORD_VALID = valid_q;
  assign wif.WORD_IDX   = widx_q;
  assign SEQ_BUSY       = busy_q;
  assign SEQ_DONE       = done_q;
  assign SEQ_ERR        = err_q;

endmodule

// File: doc/adrf_reg_sequencer.md
Name: adrf_reg_sequencer

Overview:
Upstream word source for the ADRF SPI serializer.
- Waits for CMT_LOCKED to be stable and SPI_EN to be requested.
- Walks a parameterised table of 24-bit ADRF register words and presents them one at a time over a valid/ready handshake.
- After each word, waits for the serializer's completion pulse, then inserts an inter-word gap.
- Reports sequence busy, done and error so the control logic can release the DA path.

Parameters:
NUM_WORDS, 8, number of table entries used (1..16).
TABLE, {24'h000001,24'h010000,24'h020F00,24'h030102,24'h041234,24'h058000,24'h0600FF,24'h07A5A5}, packed table; entry 0 in the MSBs, entry i at bits [24*(NUM_WORDS-i)-1 -: 24].
LOCK_CYCLES, 1024, consecutive GCLK cycles CMT_LOCKED must be high before the sequence starts.
GAP_CYCLES, 16, idle GCLK cycles between WORD_DONE and the next WORD_VALID.
TIMEOUT_CYCLES, 4096, maximum GCLK cycles from handoff to WORD_DONE.

Ports:
GCLK  input  1  sole clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
CMT_LOCKED  input  1  clock manager lock (asynchronous source); double-flop synchronised internally.
SPI_EN  input  1  configuration request; a rising edge starts a run.
WORD_READY  input  1  serializer can accept a word.
WORD_DONE  input  1  one-cycle pulse: the accepted word has been shifted out and CS deasserted.
WORD_DATA  output  24  current register word, MSB first to the serializer.
WORD_VALID  output  1  WORD_DATA is valid.
WORD_IDX  output  4  index of the word currently presented or in flight.
SEQ_BUSY  output  1  high from run start until FINISH or ERROR.
SEQ_DONE  output  1  level, all words written.
SEQ_ERR  output  1  level, WORD_DONE timeout.

Behaviour:
- Reset values: WORD_DATA=0, WORD_VALID=0, WORD_IDX=0, SEQ_BUSY=0, SEQ_DONE=0, SEQ_ERR=0; all counters 0; state IDLE; the SPI_EN edge detector register is cleared.
- lock_s is CMT_LOCKED after a 2-flop synchroniser.
- SPI_EN is registered once for edge detection; a rise is detected one cycle after it appears.
- States:
  - IDLE: on SPI_EN rise go to LOCK_WAIT; clear SEQ_DONE and SEQ_ERR, set SEQ_BUSY.
  - LOCK_WAIT: lock counter increments while lock_s=1 and resets to 0 on any lock_s=0. When the count reaches LOCK_CYCLES, go to LOAD with idx=0.
  - LOAD: WORD_DATA <= TABLE[idx], WORD_IDX <= idx, WORD_VALID <= 1; go to HANDOFF.
  - HANDOFF: hold WORD_VALID and WORD_DATA stable until a cycle with WORD_VALID&WORD_READY. In that cycle the word is accepted; WORD_VALID drops the next cycle and the timeout counter clears. Go to WAIT_DONE.
  - WAIT_DONE: timeout counter increments each cycle. On WORD_DONE, go to GAP. If the count reaches TIMEOUT_CYCLES with no WORD_DONE, go to ERROR. A WORD_DONE arriving in the same cycle as the limit wins, so the state goes to GAP.
  - GAP: count GAP_CYCLES. If idx==NUM_WORDS-1, go to FINISH; otherwise idx+1 and go to LOAD.
  - FINISH: SEQ_DONE=1, SEQ_BUSY=0; go to IDLE. SEQ_DONE holds until the next run starts or reset.
  - ERROR: SEQ_ERR=1, SEQ_BUSY=0, WORD_VALID=0; go to IDLE. SEQ_ERR is sticky until the next SPI_EN rise or reset.
- Lock loss: lock_s=0 in any state other than IDLE or LOCK_WAIT aborts the run.
  - WORD_VALID drops next cycle, idx goes to 0 and the state returns to LOCK_WAIT.
  - SEQ_BUSY stays 1, and the run restarts from word 0 after a fresh LOCK_CYCLES.
- SPI_EN is sampled only in IDLE. Deassertion or re-rise mid-run is ignored.
- WORD_DONE outside WAIT_DONE is ignored.
- Reset mid-run: all outputs return to reset values on the next edge and no word is re-presented until a new SPI_EN rise.
- Latency:
  - From the LOCK_WAIT count reaching the limit, WORD_VALID rises 2 cycles later.
  - From a WORD_DONE pulse to the next WORD_VALID rise: GAP_CYCLES+2 cycles.

Test Plan:
1. Nominal run: reset, lock_s high, SPI_EN rise; serializer model READY=1 and DONE 30 cycles after accept -> 8 words 000001..07A5A5 presented in order with WORD_IDX 0..7. SEQ_DONE=1, SEQ_BUSY=0; total words accepted = 8.
2. Lock glitch: CMT_LOCKED low for 1 cycle at lock count 1000 -> the counter restarts and WORD_VALID first rises 1024+ cycles after the glitch. Lock loss during word 3 -> restart from WORD_IDX=0.
3. Backpressure: hold WORD_READY=0 for 200 cycles on word 2 -> WORD_DATA=020F00 stays stable with WORD_VALID=1 and there is no timeout. Accept on the READY rise.
4. Timeout: never pulse WORD_DONE after word 5 accept -> SEQ_ERR=1 exactly 4096 cycles after accept; WORD_VALID=0. Next SPI_EN rise clears SEQ_ERR and restarts at word 0.
5. Boundaries:
   - WORD_DONE coincident with the timeout limit -> no error.
   - Spurious WORD_DONE in HANDOFF -> ignored.
   - Inter-word gap: WORD_VALID rises exactly 18 cycles after WORD_DONE.
6. Reset mid-run at word 4 -> outputs zeroed next cycle. SPI_EN held high with no new rise -> no restart.
